// File: rtl/rdyval_pipe_buf.sv
// Elastic ready/valid pipeline buffer: DEPTH-entry circular store with registered
// rdy/vld_nxt so neither side sees a combinational path from the other.
module rdyval_pipe_buf #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vld,
    output logic                       rdy,
    input  logic [DWIDTH-1:0]          i_dat,
    output logic                       vld_nxt,
    input  logic                       rdy_nxt,
    output logic [DWIDTH-1:0]          o_dat,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);

    if (DEPTH < 1 || DWIDTH < 1) begin : g_param_check
        $error("rdyval_pipe_buf: DEPTH and DWIDTH must both be >= 1");
    end

    // Handshake: a word moves on a side only in a cycle where both its valid and
    // ready are high (push = vld & rdy, pop = vld_nxt & rdy_nxt); a source must
    // hold its word until that happens.
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_next;
    logic [PW-1:0]     rd_ptr_next;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;

    assign push = vld & rdy;
    assign pop  = vld_nxt & rdy_nxt;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = (wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = (rd_ptr == LAST_P) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // rdy/vld_nxt are registered from next-state occupancy, so a pop while full
    // only reopens rdy in the following cycle (no same-cycle bypass).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rdy     <= 1'b1;
            vld_nxt <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            rdy     <= (count_next != FULL_C);
            vld_nxt <= (count_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= i_dat;
        end
    end

    assign o_dat = mem[rd_ptr];

endmodule

// File: doc/rdyval_pipe_buf.md
Name: rdyval_pipe_buf

Overview:
- Parametrised elastic pipeline buffer for the ready-valid handshake protocol.
- Holds up to DEPTH words in a circular store and accepts a new word every cycle while not full.
- Cuts all combinational paths between the input and output sides: rdy does not depend on rdy_nxt, and vld_nxt/o_dat do not depend on vld/i_dat.
- Successor of the single-entry pipe stage; adds configurable depth, full throughput for DEPTH>=2, occupancy reporting and synchronous flush.

Parameters:
DWIDTH, 8, data word width in bits (>=1)
DEPTH, 2, number of buffer entries (>=1, need not be a power of two)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
vld  input  1  upstream valid
rdy  output  1  upstream ready
i_dat  input  DWIDTH  upstream data
vld_nxt  output  1  downstream valid
rdy_nxt  input  1  downstream ready
o_dat  output  DWIDTH  downstream data
flush  input  1  synchronous clear of all stored words
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state (rst=1): count=0, write and read pointers=0, rdy=1, vld_nxt=0. Storage array is not reset; o_dat is don't-care while vld_nxt=0.
- Events: push = vld & rdy; pop = vld_nxt & rdy_nxt.
- rdy and vld_nxt are flop outputs computed from next-state occupancy:
  - rdy = (count_next != DEPTH)
  - vld_nxt = (count_next != 0)
- Push: the word is written at the write pointer; the write pointer advances; count increments.
- Pop: the read pointer advances; count decrements.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointer wrap: DEPTH-1 -> 0. Pointer width is $clog2(DEPTH), minimum 1. Non-power-of-2 depths must wrap correctly.
- o_dat = storage[read pointer]. Pushed data appears on o_dat with vld_nxt one cycle after the push (latency 1).
- While vld_nxt=1 and rdy_nxt=0, o_dat and vld_nxt hold stable until the pop.
- Full (count=DEPTH): rdy=0, no push. A pop in that cycle gives rdy=1 in the next cycle; there is no same-cycle bypass.
- Empty (count=0): vld_nxt=0, so a pop is impossible. A push makes vld_nxt=1 next cycle.
- Throughput:
  - DEPTH>=2: one word per cycle sustained when downstream is always ready.
  - DEPTH=1: one word per two cycles, i.e. equivalent to the single-entry stage.
- Upstream rdy=0 is not an error. A vld with rdy=0 simply does not push; the upstream must hold its word.
- flush=1 (synchronous, highest priority after reset):
  - next cycle: count=0, pointers=0, vld_nxt=0, rdy=1
  - a push or pop presented in the flush cycle is discarded; downstream must ignore a coincident handshake
- rst asserted mid-operation: all outputs go to reset values immediately (asynchronously). Stored words are lost.
- Elaboration error if DEPTH<1 or DWIDTH<1.
- Invariant: count <= DEPTH at all times. count equals (pushes - pops) since the last reset or flush.

Test Plan:
- Reset, DEPTH=4, DWIDTH=8 -> rdy=1, vld_nxt=0, count=0. Assert rst asynchronously mid-cycle with count=3 -> outputs return to reset values before the next clk edge.
- rdy_nxt=0; push 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1..4, rdy=0 after the 4th push, o_dat=0x11 stable. Then rdy_nxt=1 for 4 cycles -> o_dat 0x11,0x22,0x33,0x44 in order, count=0, vld_nxt=0.
- Streaming, DEPTH=2, vld=1 and rdy_nxt=1 for 20 cycles with an incrementing counter as data -> one pop per cycle after 1 cycle latency, data in order, no gaps.
- DEPTH=3 (non-power-of-2), random vld/rdy_nxt with 50% duty over 1000 cycles -> scoreboard shows no loss, duplication or reordering; count matches the model each cycle; pointers wrap 2 -> 0.
- Full with simultaneous pop, DEPTH=2: count=2, vld=1, rdy_nxt=1 -> count=1 and no push that cycle; rdy=1 next cycle; push completes one cycle later.
- Flush with count=2 while vld=1, rdy_nxt=1 -> next cycle count=0, vld_nxt=0, rdy=1; a subsequent push of 0xA5 appears on o_dat one cycle later.
- DEPTH=1 streaming with vld=1, rdy_nxt=1 -> exactly one transfer every 2 cycles.
